// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch-address generator with stall/back-pressure handling,
//            branch buffering and flush redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int                INST_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              imem_ready,
   input  logic              br_flag,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_target,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              redirect,
   output logic              misalign
);

   // Low bits that must be zero in any fetch address; empty when INST_BYTES=1.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] pend, pend_nxt;
   logic              pend_v, pend_v_nxt;
   logic              load;
   logic [ADDR_W-1:0] tgt;
   logic              adv;

   assign adv = (state == RUN) && !stall && imem_ready;
   assign ce  = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BOOT;
         pc       <= RESET_VEC;
         pend     <= '0;
         pend_v   <= 1'b0;
         redirect <= 1'b0;
         misalign <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         pend     <= pend_nxt;
         pend_v   <= pend_v_nxt;
         redirect <= load;
         misalign <= load && ((tgt & ALIGN_MASK) != '0);
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      pend_nxt   = pend;
      pend_v_nxt = pend_v;
      load       = 1'b0;
      tgt        = pc;
      case (state)
         BOOT: begin
            state_nxt = RUN;
            if (flush) begin
               load = 1'b1;
               tgt  = flush_target;
            end
         end
         RUN: begin
            if (flush) begin
               load       = 1'b1;
               tgt        = flush_target;
               pend_v_nxt = 1'b0;
            end else if (br_flag && adv) begin
               // A fresh branch supersedes any older buffered one.
               load       = 1'b1;
               tgt        = br_target;
               pend_v_nxt = 1'b0;
            end else if (br_flag) begin
               pend_nxt   = br_target;
               pend_v_nxt = 1'b1;
            end else if (pend_v && adv) begin
               load       = 1'b1;
               tgt        = pend;
               pend_v_nxt = 1'b0;
            end else if (adv) begin
               pc_nxt = pc + STEP;
            end
         end
         default: state_nxt = BOOT;
      endcase
      if (load) begin
         pc_nxt = tgt & ~ALIGN_MASK;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen: directed scenarios plus random
//            traffic against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst, stall, imem_ready, br_flag, flush;
   logic [31:0] br_target, flush_target;
   logic [31:0] pc;
   logic        ce, redirect, misalign;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   bit          m_run, m_red, m_mis;
   logic [31:0] pend_q[$];

   always #5 clk = ~clk;

   pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .INST_BYTES(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
      .br_flag(br_flag), .br_target(br_target), .flush(flush),
      .flush_target(flush_target), .pc(pc), .ce(ce),
      .redirect(redirect), .misalign(misalign)
   );

   // Apply the current inputs to the model, then clock the DUT and settle.
   task automatic tick();
      bit          adv, ld;
      logic [31:0] t;
      ld = 0;
      t  = '0;
      if (rst) begin
         m_pc = 32'h0; m_run = 0; m_red = 0; m_mis = 0;
         pend_q.delete();
      end else begin
         adv = m_run && !stall && imem_ready;
         if (!m_run) begin
            if (flush) begin ld = 1; t = flush_target; end
            m_run = 1;
         end else if (flush) begin
            ld = 1; t = flush_target; pend_q.delete();
         end else if (br_flag) begin
            if (adv) begin ld = 1; t = br_target; pend_q.delete(); end
            else begin pend_q.delete(); pend_q.push_back(br_target); end
         end else if (adv) begin
            if (pend_q.size() > 0) begin ld = 1; t = pend_q.pop_front(); end
            else m_pc = m_pc + 32'd4;
         end
         m_red = ld;
         m_mis = ld && (t % 4 != 0);
         if (ld) m_pc = t - (t % 4);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; imem_ready = 1; br_flag = 0; flush = 0;
      br_target = '0; flush_target = '0;
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got=%0b exp=0", ce); end
         n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc); end
         n_checks++; if (redirect !== 1'b0 || misalign !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got=%0b%0b exp=00", redirect, misalign); end
      end
      rst = 0;
      tick();
      n_checks++; if (ce !== 1'b1 || pc !== 32'h0) begin
         n_fail++; $display("FAIL boot_first got ce=%0b pc=%h exp ce=1 pc=0", ce, pc); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++; if (pc !== 32'(4 * i)) begin
            n_fail++; $display("FAIL boot_seq got=%h exp=%h", pc, 32'(4 * i)); end
      end
   endtask

   task automatic test_stall();
      tick();
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL stall_pre got=%h exp=10", pc); end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL stall_hold got=%h exp=10", pc); end
      end
      stall = 0; imem_ready = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL bp_hold got=%h exp=10", pc); end
      end
      imem_ready = 1;
      tick();
      n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL stall_release got=%h exp=14", pc); end
   endtask

   task automatic test_buffered_branch();
      flush = 1; flush_target = 32'h20;
      tick();
      flush = 0;
      n_checks++; if (pc !== 32'h20 || redirect !== 1'b1) begin
         n_fail++; $display("FAIL bb_setup got pc=%h red=%0b exp pc=20 red=1", pc, redirect); end
      stall = 1; br_flag = 1; br_target = 32'h100;
      tick();
      br_flag = 0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL bb_hold got=%h exp=20", pc); end
         if (i < 2) tick();
      end
      stall = 0;
      tick();
      n_checks++; if (pc !== 32'h100 || redirect !== 1'b1) begin
         n_fail++; $display("FAIL bb_apply got pc=%h red=%0b exp pc=100 red=1", pc, redirect); end
      tick();
      n_checks++; if (pc !== 32'h104 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL bb_next got pc=%h red=%0b exp pc=104 red=0", pc, redirect); end
   endtask

   task automatic test_flush_priority();
      stall = 1; br_flag = 1; br_target = 32'h300;
      tick();
      br_target = 32'h200; flush = 1; flush_target = 32'h80;
      tick();
      br_flag = 0; flush = 0;
      n_checks++; if (pc !== 32'h80 || redirect !== 1'b1) begin
         n_fail++; $display("FAIL fp_flush got pc=%h red=%0b exp pc=80 red=1", pc, redirect); end
      tick();
      n_checks++; if (pc !== 32'h80 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL fp_hold got pc=%h red=%0b exp pc=80 red=0", pc, redirect); end
      stall = 0;
      tick();
      n_checks++; if (pc !== 32'h84) begin n_fail++; $display("FAIL fp_release got=%h exp=84", pc); end
      tick();
      n_checks++; if (pc !== 32'h88) begin n_fail++; $display("FAIL fp_no_pending got=%h exp=88", pc); end
   endtask

   task automatic test_misalign_wrap();
      br_flag = 1; br_target = 32'h1002;
      tick();
      br_flag = 0;
      n_checks++; if (pc !== 32'h1000 || misalign !== 1'b1 || redirect !== 1'b1) begin
         n_fail++; $display("FAIL mis_apply got pc=%h mis=%0b red=%0b exp pc=1000 mis=1 red=1",
                            pc, misalign, redirect); end
      tick();
      n_checks++; if (pc !== 32'h1004 || misalign !== 1'b0) begin
         n_fail++; $display("FAIL mis_clear got pc=%h mis=%0b exp pc=1004 mis=0", pc, misalign); end
      flush = 1; flush_target = 32'hFFFF_FFFC;
      tick();
      flush = 0;
      n_checks++; if (pc !== 32'hFFFF_FFFC || misalign !== 1'b0) begin
         n_fail++; $display("FAIL wrap_setup got pc=%h mis=%0b exp pc=fffffffc mis=0", pc, misalign); end
      tick();
      n_checks++; if (pc !== 32'h0 || redirect !== 1'b0 || misalign !== 1'b0) begin
         n_fail++; $display("FAIL wrap got pc=%h red=%0b mis=%0b exp pc=0 red=0 mis=0",
                            pc, redirect, misalign); end
   endtask

   task automatic test_reset_mid();
      stall = 1; br_flag = 1; br_target = 32'h500;
      tick();
      br_flag = 0; rst = 1;
      tick();
      n_checks++; if (pc !== 32'h0 || ce !== 1'b0 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL rm_reset got pc=%h ce=%0b red=%0b exp pc=0 ce=0 red=0", pc, ce, redirect); end
      rst = 0; stall = 0;
      tick();
      n_checks++; if (pc !== 32'h0 || ce !== 1'b1 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL rm_boot got pc=%h ce=%0b red=%0b exp pc=0 ce=1 red=0", pc, ce, redirect); end
      tick();
      n_checks++; if (pc !== 32'h4 || redirect !== 1'b0) begin
         n_fail++; $display("FAIL rm_no_pending got pc=%h red=%0b exp pc=4 red=0", pc, redirect); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst          = ($urandom_range(0, 59) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         imem_ready   = ($urandom_range(0, 3) != 0);
         br_flag      = ($urandom_range(0, 5) == 0);
         flush        = ($urandom_range(0, 11) == 0);
         br_target    = $urandom;
         flush_target = $urandom;
         tick();
         n_checks++;
         if (pc !== m_pc || ce !== m_run || redirect !== m_red || misalign !== m_mis) begin
            n_fail++;
            $display("FAIL rand[%0d] got pc=%h ce=%0b red=%0b mis=%0b exp pc=%h ce=%0b red=%0b mis=%0b",
                     i, pc, ce, redirect, misalign, m_pc, m_run, m_red, m_mis);
         end
      end
      idle_inputs();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_stall();
      test_buffered_branch();
      test_flush_priority();
      test_misalign_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter / fetch-address generator for the in-order CPU core.
- Drives the instruction-memory address and chip-enable.
- Steps sequentially by a configurable instruction size.
- Honours pipeline stall and instruction-memory back-pressure.
- Accepts branch/jump redirects from decode and flush/exception redirects from the control unit.
- Buffers a branch that arrives while fetch cannot advance.

Parameters:
ADDR_W, 32, width of pc and of all target buses.
RESET_VEC, 32'h00000000, first fetch address after reset.
INST_BYTES, 4, sequential increment in bytes; power of two ≥1. ALIGN_B = log2(INST_BYTES) low bits must be zero.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
stall  input  1  pipeline stall from control; holds pc.
imem_ready  input  1  instruction memory accepts the current fetch this cycle.
br_flag  input  1  branch/jump taken, one-cycle pulse.
br_target  input  ADDR_W  branch/jump destination.
flush  input  1  exception/flush redirect, one-cycle pulse.
flush_target  input  ADDR_W  handler/return address.
pc  output  ADDR_W  current fetch address.
ce  output  1  instruction-memory chip enable (fetch request valid).
redirect  output  1  one-cycle pulse: pc was loaded from a target this edge.
misalign  output  1  one-cycle pulse: an applied target had nonzero low ALIGN_B bits.

Behaviour:
- Reset is synchronous: rst=1 at a rising edge gives:
  - pc=RESET_VEC, ce=0, redirect=0, misalign=0.
  - Pending-branch register cleared.
  - Applies mid-operation and overrides all other inputs.
- State machine (2 states):
  - BOOT: entered on reset; ce=0. The first edge with rst=0 goes to RUN and sets ce=1. pc stays RESET_VEC, so the first fetch is at RESET_VEC. Inputs are ignored in BOOT except flush: flush in BOOT loads flush_target and still moves to RUN.
  - RUN: ce=1 permanently until the next reset.
- Advance condition: adv = RUN & ~stall & imem_ready.
- Per-edge priority in RUN:
  1. flush: pc<=flush_target (aligned), pending cleared, redirect=1. Applies regardless of stall or imem_ready. A simultaneous br_flag is discarded.
  2. br_flag & adv: pc<=br_target (aligned), redirect=1.
  3. br_flag & ~adv: pending<=br_target, pend_v<=1, pc held. A later br_flag during the same hold overwrites pending (last wins).
  4. pend_v & adv: pc<=pending (aligned), pend_v<=0, redirect=1.
  5. adv: pc<=pc+INST_BYTES, modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0 with no flag.
  6. Otherwise pc holds.
- Alignment:
  - Any target loaded into pc has its low ALIGN_B bits forced to 0.
  - If those bits were nonzero, misalign=1 for that one cycle; the redirect still happens.
  - INST_BYTES=1 means no alignment and misalign is always 0.
- Pulse outputs: redirect and misalign are registered and asserted in the cycle after the loading edge. They are 0 otherwise.
- Latency: redirect input to new pc is 1 cycle when adv or flush holds. A buffered branch applies on the first edge where adv=1.
- RESET_VEC must be aligned; this is not checked in hardware.

Test Plan:
1. Reset/boot: rst=1 for 2 cycles, then 0, stall=0, imem_ready=1.
   - During reset: ce=0, pc=0.
   - First cycle after release: ce=1, pc=0.
   - Following cycles: pc=4, 8, 12.
2. Stall/back-pressure: pc=0x10, stall=1 for 3 cycles, then imem_ready=0 for 2 cycles.
   - pc holds at 0x10 throughout.
   - After release, pc=0x14.
3. Buffered branch: pc=0x20, stall=1, br_flag pulse with target 0x100, then 2 stall cycles.
   - pc holds at 0x20.
   - Edge after stall drops: pc=0x100, redirect=1.
   - Next edge: pc=0x104.
4. Flush priority: same edge br_flag (target 0x200) + flush (target 0x80) while stall=1 and a branch to 0x300 is pending.
   - pc=0x80, redirect=1.
   - Pending cleared: pc=0x84 on release, never 0x300.
5. Misalign + wrap:
   - Branch to 0x1002: pc=0x1000, misalign=1 for exactly one cycle.
   - Separately, pc=0xFFFFFFFC advancing gives pc=0x00000000.
6. Reset mid-operation: rst=1 while a branch is pending and stall=1.
   - pc=RESET_VEC, ce=0, pend_v=0.
   - After release, fetch restarts at RESET_VEC with no redirect pulse.
